// File: rtl/vg_pkg.sv
// Shared types for the video timing path: mode indices, the timing parameter
// bundle, the mode-change controller state encoding and the mode ROM contents.
package vg_pkg;

    localparam int VG_X_BITS = 12;
    localparam int VG_Y_BITS = 12;

    localparam logic [2:0] MODE_480P  = 3'd0;
    localparam logic [2:0] MODE_720P  = 3'd1;
    localparam logic [2:0] MODE_1080I = 3'd2;
    localparam logic [2:0] MODE_1080P = 3'd3;
    localparam int         NUM_MODES  = 4;

    typedef struct packed {
        logic                 interlaced;
        logic [VG_Y_BITS-1:0] v_total_0;
        logic [VG_Y_BITS-1:0] v_fp_0;
        logic [VG_Y_BITS-1:0] v_bp_0;
        logic [VG_Y_BITS-1:0] v_sync_0;
        logic [VG_Y_BITS-1:0] v_total_1;
        logic [VG_Y_BITS-1:0] v_fp_1;
        logic [VG_Y_BITS-1:0] v_bp_1;
        logic [VG_Y_BITS-1:0] v_sync_1;
        logic [VG_X_BITS-1:0] h_total;
        logic [VG_X_BITS-1:0] h_fp;
        logic [VG_X_BITS-1:0] h_bp;
        logic [VG_X_BITS-1:0] h_sync;
        logic [VG_X_BITS-1:0] hv_offset_0;
        logic [VG_X_BITS-1:0] hv_offset_1;
    } vg_timing_t;

    typedef enum logic [2:0] {
        ST_BOOT       = 3'd0,
        ST_RUN        = 3'd1,
        ST_WAIT_FRAME = 3'd2,
        ST_LOAD       = 3'd3,
        ST_SETTLE     = 3'd4
    } vg_state_t;

    function automatic vg_timing_t vg_make(
        input logic                 ilace,
        input logic [VG_X_BITS-1:0] ht, input logic [VG_X_BITS-1:0] hf,
        input logic [VG_X_BITS-1:0] hb, input logic [VG_X_BITS-1:0] hs,
        input logic [VG_Y_BITS-1:0] v0t, input logic [VG_Y_BITS-1:0] v0f,
        input logic [VG_Y_BITS-1:0] v0b, input logic [VG_Y_BITS-1:0] v0s,
        input logic [VG_Y_BITS-1:0] v1t, input logic [VG_Y_BITS-1:0] v1f,
        input logic [VG_Y_BITS-1:0] v1b, input logic [VG_Y_BITS-1:0] v1s,
        input logic [VG_X_BITS-1:0] hvo0, input logic [VG_X_BITS-1:0] hvo1);
        vg_timing_t t;
        t.interlaced  = ilace;
        t.h_total     = ht;
        t.h_fp        = hf;
        t.h_bp        = hb;
        t.h_sync      = hs;
        t.v_total_0   = v0t;
        t.v_fp_0      = v0f;
        t.v_bp_0      = v0b;
        t.v_sync_0    = v0s;
        t.v_total_1   = v1t;
        t.v_fp_1      = v1f;
        t.v_bp_1      = v1b;
        t.v_sync_1    = v1s;
        t.hv_offset_0 = hvo0;
        t.hv_offset_1 = hvo1;
        return t;
    endfunction

    // Progressive modes repeat field-0 vertical timing in field 1.
    function automatic vg_timing_t vg_mode_lookup(input logic [2:0] mode);
        vg_timing_t t;
        case (mode)
            MODE_480P: t = vg_make(1'b0, 12'd800, 12'd16, 12'd48, 12'd96,
                                   12'd525, 12'd10, 12'd33, 12'd2,
                                   12'd525, 12'd10, 12'd33, 12'd2, 12'd0, 12'd0);
            MODE_720P: t = vg_make(1'b0, 12'd1650, 12'd110, 12'd220, 12'd40,
                                   12'd750, 12'd5, 12'd20, 12'd5,
                                   12'd750, 12'd5, 12'd20, 12'd5, 12'd0, 12'd0);
            MODE_1080I: t = vg_make(1'b1, 12'd2200, 12'd88, 12'd148, 12'd44,
                                    12'd562, 12'd2, 12'd15, 12'd5,
                                    12'd563, 12'd2, 12'd16, 12'd5, 12'd0, 12'd1100);
            MODE_1080P: t = vg_make(1'b0, 12'd2200, 12'd88, 12'd148, 12'd44,
                                    12'd1125, 12'd4, 12'd36, 12'd5,
                                    12'd1125, 12'd4, 12'd36, 12'd5, 12'd0, 12'd0);
            default: t = vg_make(1'b0, 12'd800, 12'd16, 12'd48, 12'd96,
                                 12'd525, 12'd10, 12'd33, 12'd2,
                                 12'd525, 12'd10, 12'd33, 12'd2, 12'd0, 12'd0);
        endcase
        return t;
    endfunction

endpackage

// File: rtl/vg_mode_ctrl_if.sv
// Mode-change request handshake between host/config logic and the controller.
interface vg_mode_ctrl_if;
    logic       req_valid;
    logic [2:0] req_mode;
    logic       req_ready;

    modport master (output req_valid, output req_mode, input req_ready);
    modport slave  (input req_valid, input req_mode, output req_ready);
endinterface

// File: rtl/vg_mode_table.sv
// Registered mode ROM: mode index in, full timing parameter set out one cycle later.
module vg_mode_table
    import vg_pkg::*;
#(
    parameter int RESET_MODE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] mode_i,
    output vg_timing_t timing_o
);

    vg_timing_t timing_q;

    // ROM read register
    always_ff @(posedge clk) begin
        if (reset) begin
            timing_q <= vg_mode_lookup(3'(RESET_MODE));
        end else begin
            timing_q <= vg_mode_lookup(mode_i);
        end
    end

    assign timing_o = timing_q;

endmodule

// File: rtl/vg_mode_ctrl.sv
// Mode-change sequencer: accepts a mode request, waits for a frame boundary or
// timeout, holds the timing generator in reset while new parameters load and settle.
module vg_mode_ctrl
    import vg_pkg::*;
#(
    parameter int X_BITS         = 12,
    parameter int Y_BITS         = 12,
    parameter int DEFAULT_MODE   = 1,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic              clk,
    input  logic              reset,
    vg_mode_ctrl_if.slave     req,
    input  logic              vs_in,
    output logic              tg_run,
    output logic              interlaced,
    output logic [Y_BITS-1:0] v_total_0,
    output logic [Y_BITS-1:0] v_fp_0,
    output logic [Y_BITS-1:0] v_bp_0,
    output logic [Y_BITS-1:0] v_sync_0,
    output logic [Y_BITS-1:0] v_total_1,
    output logic [Y_BITS-1:0] v_fp_1,
    output logic [Y_BITS-1:0] v_bp_1,
    output logic [Y_BITS-1:0] v_sync_1,
    output logic [X_BITS-1:0] h_total,
    output logic [X_BITS-1:0] h_fp,
    output logic [X_BITS-1:0] h_bp,
    output logic [X_BITS-1:0] h_sync,
    output logic [X_BITS-1:0] hv_offset_0,
    output logic [X_BITS-1:0] hv_offset_1,
    output logic [2:0]        cur_mode,
    output logic              done,
    output logic              err,
    output logic              timeout
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [2:0] DEF_MODE = 3'(DEFAULT_MODE);

    vg_state_t        state_q;
    vg_timing_t       params_q;
    vg_timing_t       tbl_s;
    logic [2:0]       target_q;
    logic [2:0]       cur_mode_q;
    logic             tg_run_q;
    logic             req_ready_q;
    logic             done_q;
    logic             err_q;
    logic             timeout_q;
    logic             boot_q;
    logic             load_ph_q;
    logic             vs_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [ST_W-1:0]  st_cnt_q;
    logic             vs_edge_s;

    vg_mode_table #(.RESET_MODE(DEFAULT_MODE)) u_table (
        .clk      (clk),
        .reset    (reset),
        .mode_i   (target_q),
        .timing_o (tbl_s)
    );

    assign vs_edge_s = vs_in & ~vs_q;

    // Controller FSM; every output is set alongside the transition that implies it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            params_q    <= vg_mode_lookup(DEF_MODE);
            target_q    <= DEF_MODE;
            cur_mode_q  <= DEF_MODE;
            tg_run_q    <= 1'b0;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            boot_q      <= 1'b1;
            load_ph_q   <= 1'b0;
            vs_q        <= 1'b0;
            to_cnt_q    <= '0;
            st_cnt_q    <= '0;
        end else begin
            vs_q      <= vs_in;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_BOOT: begin
                    target_q  <= DEF_MODE;
                    boot_q    <= 1'b1;
                    load_ph_q <= 1'b0;
                    state_q   <= ST_LOAD;
                end
                ST_RUN: begin
                    if (req.req_valid && req_ready_q) begin
                        if (req.req_mode < 3'(NUM_MODES)) begin
                            target_q    <= req.req_mode;
                            to_cnt_q    <= '0;
                            req_ready_q <= 1'b0;
                            state_q     <= ST_WAIT_FRAME;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                // A frame edge on the terminal count takes priority over the timeout
                ST_WAIT_FRAME: begin
                    if (vs_edge_s) begin
                        tg_run_q  <= 1'b0;
                        load_ph_q <= 1'b0;
                        state_q   <= ST_LOAD;
                    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        tg_run_q  <= 1'b0;
                        load_ph_q <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= ST_LOAD;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (!load_ph_q) begin
                        load_ph_q <= 1'b1;
                    end else begin
                        params_q   <= tbl_s;
                        cur_mode_q <= target_q;
                        st_cnt_q   <= '0;
                        state_q    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (st_cnt_q == ST_W'(SETTLE_CYCLES - 1)) begin
                        tg_run_q    <= 1'b1;
                        req_ready_q <= 1'b1;
                        done_q      <= ~boot_q;
                        boot_q      <= 1'b0;
                        state_q     <= ST_RUN;
                    end else begin
                        st_cnt_q <= st_cnt_q + ST_W'(1);
                    end
                end
                default: begin
                    tg_run_q    <= 1'b0;
                    req_ready_q <= 1'b0;
                    state_q     <= ST_BOOT;
                end
            endcase
        end
    end

    assign req.req_ready = req_ready_q;
    assign tg_run        = tg_run_q;
    assign cur_mode      = cur_mode_q;
    assign done          = done_q;
    assign err           = err_q;
    assign timeout       = timeout_q;
    assign interlaced    = params_q.interlaced;
    assign v_total_0     = Y_BITS'(params_q.v_total_0);
    assign v_fp_0        = Y_BITS'(params_q.v_fp_0);
    assign v_bp_0        = Y_BITS'(params_q.v_bp_0);
    assign v_sync_0      = Y_BITS'(params_q.v_sync_0);
    assign v_total_1     = Y_BITS'(params_q.v_total_1);
    assign v_fp_1        = Y_BITS'(params_q.v_fp_1);
    assign v_bp_1        = Y_BITS'(params_q.v_bp_1);
    assign v_sync_1      = Y_BITS'(params_q.v_sync_1);
    assign h_total       = X_BITS'(params_q.h_total);
    assign h_fp          = X_BITS'(params_q.h_fp);
    assign h_bp          = X_BITS'(params_q.h_bp);
    assign h_sync        = X_BITS'(params_q.h_sync);
    assign hv_offset_0   = X_BITS'(params_q.hv_offset_0);
    assign hv_offset_1   = X_BITS'(params_q.hv_offset_1);

endmodule

// File: tb/tb_vg_mode_ctrl.sv
// Scoreboard bench for vg_mode_ctrl: stimulus pushes expected events, a negedge
// monitor pops them when the DUT raises tg_run, err or timeout.
module tb_vg_mode_ctrl;

    localparam int SETTLE = 16;
    localparam int TMO    = 64;
    localparam int EV_RUN = 0;
    localparam int EV_ERR = 1;
    localparam int EV_TO  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vs_in = 1'b0;
    logic        tg_run, interlaced, done, err, timeout;
    logic [11:0] v_total_0, v_fp_0, v_bp_0, v_sync_0;
    logic [11:0] v_total_1, v_fp_1, v_bp_1, v_sync_1;
    logic [11:0] h_total, h_fp, h_bp, h_sync, hv_offset_0, hv_offset_1;
    logic [2:0]  cur_mode;

    always #5 clk = ~clk;

    vg_mode_ctrl_if req_if ();

    vg_mode_ctrl #(
        .X_BITS(12), .Y_BITS(12), .DEFAULT_MODE(1),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req(req_if), .vs_in(vs_in), .tg_run(tg_run),
        .interlaced(interlaced),
        .v_total_0(v_total_0), .v_fp_0(v_fp_0), .v_bp_0(v_bp_0), .v_sync_0(v_sync_0),
        .v_total_1(v_total_1), .v_fp_1(v_fp_1), .v_bp_1(v_bp_1), .v_sync_1(v_sync_1),
        .h_total(h_total), .h_fp(h_fp), .h_bp(h_bp), .h_sync(h_sync),
        .hv_offset_0(hv_offset_0), .hv_offset_1(hv_offset_1),
        .cur_mode(cur_mode), .done(done), .err(err), .timeout(timeout)
    );

    // Reference mode table, straight from the published video timings
    int H_TOT [4] = '{800, 1650, 2200, 2200};
    int H_FP  [4] = '{16, 110, 88, 88};
    int H_BP  [4] = '{48, 220, 148, 148};
    int H_SY  [4] = '{96, 40, 44, 44};
    int V0_T  [4] = '{525, 750, 562, 1125};
    int V0_F  [4] = '{10, 5, 2, 4};
    int V0_B  [4] = '{33, 20, 15, 36};
    int V0_S  [4] = '{2, 5, 5, 5};
    int V1_T  [4] = '{525, 750, 563, 1125};
    int V1_B  [4] = '{33, 20, 16, 36};
    int ILACE [4] = '{0, 0, 1, 0};
    int HVO1  [4] = '{0, 0, 1100, 0};

    typedef struct {
        int kind;
        int mode;
        bit done;
        bit boot;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    wire [171:0] par_vec = {interlaced, cur_mode, v_total_0, v_fp_0, v_bp_0, v_sync_0,
                            v_total_1, v_fp_1, v_bp_1, v_sync_1, h_total, h_fp, h_bp,
                            h_sync, hv_offset_0, hv_offset_1};

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int mode, input bit dn, input bit boot);
        ev_t e;
        e.kind = kind;
        e.mode = mode;
        e.done = dn;
        e.boot = boot;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, output ev_t e, output bit got);
        got = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual_kind=%0d expected=none at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            got = (e.kind == kind);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic        prev_tg;
        int          low_cnt;
        logic [171:0] snap;
        ev_t         e;
        bit          got;
        prev_tg = 1'b0;
        low_cnt = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                low_cnt = 0;
                prev_tg = tg_run;
            end else begin
                if (err) expect_ev(EV_ERR, e, got);
                if (timeout) expect_ev(EV_TO, e, got);
                if (tg_run && !prev_tg) begin
                    expect_ev(EV_RUN, e, got);
                    if (got) begin
                        chk("done_on_run", done, e.done);
                        chk("cur_mode", cur_mode, e.mode);
                        chk("low_cycles", low_cnt, e.boot ? 3 + SETTLE : 2 + SETTLE);
                        chk("h_total", h_total, H_TOT[e.mode]);
                        chk("h_fp", h_fp, H_FP[e.mode]);
                        chk("h_bp", h_bp, H_BP[e.mode]);
                        chk("h_sync", h_sync, H_SY[e.mode]);
                        chk("v_total_0", v_total_0, V0_T[e.mode]);
                        chk("v_fp_0", v_fp_0, V0_F[e.mode]);
                        chk("v_bp_0", v_bp_0, V0_B[e.mode]);
                        chk("v_sync_0", v_sync_0, V0_S[e.mode]);
                        chk("v_total_1", v_total_1, V1_T[e.mode]);
                        chk("v_fp_1", v_fp_1, V0_F[e.mode]);
                        chk("v_bp_1", v_bp_1, V1_B[e.mode]);
                        chk("v_sync_1", v_sync_1, V0_S[e.mode]);
                        chk("interlaced", interlaced, ILACE[e.mode]);
                        chk("hv_offset_0", hv_offset_0, 0);
                        chk("hv_offset_1", hv_offset_1, HVO1[e.mode]);
                    end
                    snap = par_vec;
                    low_cnt = 0;
                end else begin
                    if (done) chk("spurious_done", done, 0);
                    if (tg_run && prev_tg) begin
                        checks++;
                        if (par_vec !== snap) begin
                            failures++;
                            $display("FAIL param_stable actual=%h expected=%h at %0t",
                                     par_vec, snap, $time);
                        end
                    end
                    if (!tg_run) begin
                        low_cnt++;
                        chk("ready_while_held", req_if.req_ready, 0);
                    end
                end
                prev_tg = tg_run;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept(input logic [2:0] m);
        bit ok;
        ok = 1'b0;
        req_if.req_valid = 1'b1;
        req_if.req_mode  = m;
        for (int c = 0; c < 400; c++) begin
            if (req_if.req_ready) begin
                cyc(1);
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
        chk("accept_in_budget", ok, 1);
    endtask

    // Raise vs_in j cycles after acceptance; j<0 keeps it low (forces timeout)
    task automatic wait_frame(input int j);
        if (j >= 0) begin
            cyc(j);
            if (j < TMO) chk("tg_run_before_edge", tg_run, 1);
            vs_in = 1'b1;
            cyc(1);
            if (j < TMO) chk("tg_run_fall", tg_run, 0);
            cyc(3);
            vs_in = 1'b0;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 400; c++) begin
            if (exp_q.size() == 0) break;
            cyc(1);
        end
        chk("scoreboard_drain", exp_q.size(), 0);
        exp_q.delete();
        cyc(2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        chk("rst_tg_run", tg_run, 0);
        chk("rst_cur_mode", cur_mode, 1);
        chk("rst_h_total", h_total, 1650);
        chk("rst_v_total_0", v_total_0, 750);
        chk("rst_interlaced", interlaced, 0);
        chk("rst_pulses", {done, err, timeout}, 0);
        chk("rst_ready", req_if.req_ready, 0);
        push(EV_RUN, 1, 1'b0, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int m, r, j;
        req_if.req_valid = 1'b0;
        req_if.req_mode  = 3'd0;
        cyc(1);
        do_reset();
        drain();

        accept(3'd2); req_if.req_valid = 1'b0;      // switch on a frame edge
        push(EV_RUN, 2, 1'b1, 1'b0);
        wait_frame(40);
        drain();

        accept(3'd0); req_if.req_valid = 1'b0;      // no frame edge: timeout
        push(EV_TO, 0, 1'b0, 1'b0);
        push(EV_RUN, 0, 1'b1, 1'b0);
        wait_frame(-1);
        drain();

        accept(3'd5); req_if.req_valid = 1'b0;      // invalid mode
        push(EV_ERR, 0, 1'b0, 1'b0);
        cyc(5);
        drain();

        accept(3'd3); req_if.req_valid = 1'b0;      // edge on the terminal count
        push(EV_RUN, 3, 1'b1, 1'b0);
        wait_frame(TMO - 1);
        drain();

        accept(3'd3); req_if.req_valid = 1'b0;      // reset during SETTLE
        wait_frame(10);
        cyc(6);
        chk("in_settle", tg_run, 0);
        do_reset();
        drain();

        accept(3'd2);                               // request held through a switch
        req_if.req_mode = 3'd0;
        push(EV_RUN, 2, 1'b1, 1'b0);
        wait_frame(20);
        accept(3'd0); req_if.req_valid = 1'b0;
        push(EV_RUN, 0, 1'b1, 1'b0);
        wait_frame(5);
        drain();

        for (int i = 0; i < 25; i++) begin
            m = $urandom_range(0, 7);
            accept(3'(m));
            req_if.req_valid = 1'b0;
            if (m >= 4) begin
                push(EV_ERR, 0, 1'b0, 1'b0);
                cyc(3);
            end else begin
                r = $urandom_range(0, 9);
                if (r < 6)      j = $urandom_range(0, TMO - 2);
                else if (r < 7) j = TMO - 1;
                else if (r < 8) j = $urandom_range(TMO, TMO + 16);
                else            j = -1;
                if (j < 0 || j >= TMO) push(EV_TO, m, 1'b0, 1'b0);
                push(EV_RUN, m, 1'b1, 1'b0);
                wait_frame(j);
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
